// File: rtl/control_unit_pkg.sv
// Shared opcode encodings and dispatch FSM state type for the instruction
// stream producer (program counter), this sequencer and the datapath units.
package control_unit_pkg;

  localparam logic [3:0] OP_NOP     = 4'b0000;
  localparam logic [3:0] OP_BARRIER = 4'b0001;
  localparam logic [3:0] OP_HALT    = 4'b0010;
  localparam logic [3:0] OP_RSVD    = 4'b0011;

  localparam logic [1:0] UF_CTRL = 2'b00;
  localparam logic [1:0] UF_U1   = 2'b01;
  localparam logic [1:0] UF_U2   = 2'b10;
  localparam logic [1:0] UF_U3   = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT_UNIT,
    ST_WAIT_BARRIER,
    ST_HALTED
  } dispatch_state_t;

  // One-hot unit select from the opcode unit field; control field maps to none.
  function automatic logic [2:0] unit_mask(input logic [1:0] field);
    logic [2:0] m;
    case (field)
      UF_U1:   m = 3'b001;
      UF_U2:   m = 3'b010;
      UF_U3:   m = 3'b100;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sequencer_watchdog.sv
// Hung-unit watchdog: counts idle-busy cycles and pulses fire_o once when the
// count reaches TIMEOUT_CYCLES. The counter saturates so it never re-fires.
module sequencer_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int WD_WIDTH       = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic count_en_i,
  output logic fire_o
);

  localparam logic [WD_WIDTH-1:0] LIMIT = WD_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [WD_WIDTH-1:0] LAST  = WD_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [WD_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_en_i && (count_q != LIMIT)) begin
      count_d = count_q + WD_WIDTH'(1);
    end
  end

  // Fires on the cycle whose edge makes the count reach the limit.
  assign fire_o = !clear_i && count_en_i && (count_q == LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dispatch_sequencer.sv
// Consumer side of the instruction stream: decodes opcodes into unit starts,
// tracks per-unit busy state, and handles barrier, halt and watchdog timeout.
module dispatch_sequencer
  import control_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int WD_WIDTH       = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       instr_valid_in,
  input  logic [3:0] instr_in,
  output logic       instr_ready_out,
  output logic [2:0] unit_start_out,
  output logic [1:0] unit_op_out,
  input  logic [2:0] unit_done_in,
  output logic [2:0] busy_out,
  output logic       halted_out,
  output logic       illegal_out,
  output logic       timeout_out
);

  dispatch_state_t state_q, state_d, fsm_state;
  logic            ready_en_q;
  logic [3:0]      held_q, held_d;
  logic [2:0]      start_q, start_d;
  logic [1:0]      op_q, op_d;
  logic [2:0]      busy_q, busy_d;
  logic            illegal_q, illegal_d, fsm_illegal;
  logic            timeout_q;
  logic [2:0]      busy_after_done;
  logic [2:0]      mask;
  logic            accept;
  logic            wd_clear;
  logic            wd_fire;

  // ready_en_q keeps ready low until the first edge after reset release.
  assign instr_ready_out = ready_en_q && (state_q == ST_RUN);
  assign accept          = instr_valid_in && instr_ready_out;
  assign busy_after_done = busy_q & ~unit_done_in;

  always_comb begin
    fsm_state   = state_q;
    held_d      = held_q;
    start_d     = '0;
    op_d        = '0;
    fsm_illegal = illegal_q;
    mask        = '0;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          mask = unit_mask(instr_in[3:2]);
          if (instr_in[3:2] == UF_CTRL) begin
            case (instr_in)
              OP_BARRIER: if (busy_after_done != '0) fsm_state = ST_WAIT_BARRIER;
              OP_HALT:    fsm_state = ST_HALTED;
              OP_RSVD:    fsm_illegal = 1'b1;
              default:    ;
            endcase
          end else if ((busy_after_done & mask) == '0) begin
            start_d = mask;
            op_d    = instr_in[1:0];
          end else begin
            held_d    = instr_in;
            fsm_state = ST_WAIT_UNIT;
          end
        end
      end
      ST_WAIT_UNIT: begin
        mask = unit_mask(held_q[3:2]);
        if ((busy_after_done & mask) == '0) begin
          start_d   = mask;
          op_d      = held_q[1:0];
          fsm_state = ST_RUN;
        end
      end
      ST_WAIT_BARRIER: begin
        if (busy_after_done == '0) fsm_state = ST_RUN;
      end
      ST_HALTED: ;
      default: fsm_state = ST_RUN;
    endcase
  end

  // Watchdog fire never coincides with a start (a start clears the counter),
  // so only the state and the reserved-opcode flag need overriding here.
  assign state_d   = wd_fire ? ST_HALTED : fsm_state;
  assign illegal_d = wd_fire ? illegal_q : fsm_illegal;
  assign busy_d    = busy_after_done | start_d;
  assign wd_clear  = (|unit_done_in) || (|start_d) || (busy_q == '0);

  sequencer_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .WD_WIDTH       (WD_WIDTH)
  ) u_watchdog (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .clear_i    (wd_clear),
    .count_en_i (|busy_q),
    .fire_o     (wd_fire)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_RUN;
      ready_en_q <= 1'b0;
      held_q     <= '0;
      start_q    <= '0;
      op_q       <= '0;
      busy_q     <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      held_q     <= held_d;
      start_q    <= start_d;
      op_q       <= op_d;
      busy_q     <= busy_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_q | wd_fire;
    end
  end

  assign unit_start_out = start_q;
  assign unit_op_out    = op_q;
  assign busy_out       = busy_q;
  assign halted_out     = (state_q == ST_HALTED);
  assign illegal_out    = illegal_q;
  assign timeout_out    = timeout_q;

endmodule
